// File: rtl/pio_fade_pkg.sv
// rtl/pio_fade_pkg.sv - shared state encodings and defaults for the PIO LED fader
package pio_fade_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_t;

    localparam int DEF_CHANNELS = 2;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_PRESCALE = 50000;
    localparam int DEF_STEP     = 1;

endpackage

// File: rtl/pio_led_fader_if.sv
// rtl/pio_led_fader_if.sv - ctrl/led/busy bundle between PIO out_port and the LED fader
interface pio_led_fader_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] ctrl_in;
    logic [CHANNELS-1:0] led_out;
    logic [CHANNELS-1:0] busy;

    modport master (
        output ctrl_in,
        input  led_out,
        input  busy
    );

    modport slave (
        input  ctrl_in,
        output led_out,
        output busy
    );
endinterface

// File: rtl/pio_fade_channel.sv
// rtl/pio_fade_channel.sv - one fade FSM with duty register, PWM compare and output flops
module pio_fade_channel
    import pio_fade_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP     = DEF_STEP
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                ctrl_q,
    output logic                led,
    output logic                busy
);

    localparam int                  MAX_DUTY = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(STEP);

    fade_state_t         state;
    fade_state_t         state_nxt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PWM_BITS:0]   sum_w;
    logic [PWM_BITS:0]   diff_w;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    // saturating step: one extra bit catches overflow past MAX and borrow below 0
    always_comb begin
        sum_w   = {1'b0, duty} + STEP_W;
        diff_w  = {1'b0, duty} - STEP_W;
        duty_up = (sum_w > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum_w[PWM_BITS-1:0];
        duty_dn = diff_w[PWM_BITS] ? '0 : diff_w[PWM_BITS-1:0];
    end

    // next state and duty; a reversal of ctrl_q wins over reaching the ramp end
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        case (state)
            ST_OFF: begin
                duty_nxt = '0;
                if (ctrl_q) state_nxt = ST_RISE;
            end
            ST_RISE: begin
                if (!ctrl_q)              state_nxt = ST_FALL;
                else if (duty == DUTY_MAX) state_nxt = ST_ON;
                else if (tick)            duty_nxt  = duty_up;
            end
            ST_ON: begin
                duty_nxt = DUTY_MAX;
                if (!ctrl_q) state_nxt = ST_FALL;
            end
            ST_FALL: begin
                if (ctrl_q)          state_nxt = ST_RISE;
                else if (duty == '0) state_nxt = ST_OFF;
                else if (tick)       duty_nxt  = duty_dn;
            end
            default: begin
                state_nxt = ST_OFF;
                duty_nxt  = '0;
            end
        endcase
    end

    // FSM state and duty registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_OFF;
            duty  <= '0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
        end
    end

    // registered LED drive (ON forces 100%) and ramp-in-progress flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led  <= 1'b0;
            busy <= 1'b0;
        end else begin
            led  <= (state == ST_ON) | (pwm_cnt < duty);
            busy <= (state == ST_RISE) | (state == ST_FALL);
        end
    end

endmodule

// File: rtl/pio_led_fader.sv
// rtl/pio_led_fader.sv - top: ctrl sync register, shared prescaler and PWM counter, channel array
module pio_led_fader
    import pio_fade_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int STEP     = DEF_STEP
) (
    input  logic           clk,
    input  logic           reset_n,
    pio_led_fader_if.slave bus
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [CHANNELS-1:0] ctrl_q;
    logic [PW-1:0]       presc_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CHANNELS-1:0] led_vec;
    logic [CHANNELS-1:0] busy_vec;

    assign tick = (presc_cnt == PRE_LAST);

    // one register stage on the PIO levels; the FSMs look at levels only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ctrl_q <= '0;
        else          ctrl_q <= bus.ctrl_in;
    end

    // ramp-tick prescaler shared by all channels, never restarted by ctrl changes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  presc_cnt <= '0;
        else if (tick) presc_cnt <= '0;
        else           presc_cnt <= presc_cnt + 1'b1;
    end

    // free-running PWM counter, wraps naturally every 2**PWM_BITS cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pio_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .ctrl_q  (ctrl_q[g]),
            .led     (led_vec[g]),
            .busy    (busy_vec[g])
        );
    end

    assign bus.led_out = led_vec;
    assign bus.busy    = busy_vec;

endmodule

// File: tb/tb_pio_led_fader.sv
// tb/tb_pio_led_fader.sv - randomized LED fader bench against a duty/direction reference model
module tb_pio_led_fader;

    localparam int CH   = 2;
    localparam int PB   = 4;
    localparam int PS   = 4;
    localparam int MAXD = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CH-1:0] cur = '0;

    always #5 clk = ~clk;

    pio_led_fader_if #(.CHANNELS(CH)) bus_a ();
    pio_led_fader_if #(.CHANNELS(CH)) bus_b ();

    assign bus_a.ctrl_in = cur;
    assign bus_b.ctrl_in = cur;

    pio_led_fader #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .STEP(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    pio_led_fader #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .STEP(4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference: per channel a duty level and a direction (+1 up, -1 down, 0 resting)
    int            m_duty [2][CH];
    int            m_dir  [2][CH];
    int            m_step [2] = '{1, 4};
    logic [CH-1:0] m_cq;
    int            m_cyc;
    logic [CH-1:0] exp_led  [2];
    logic [CH-1:0] exp_busy [2];

    task automatic check_eq(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                m_duty[d][c] = 0;
                m_dir[d][c]  = 0;
            end
            exp_led[d]  = '0;
            exp_busy[d] = '0;
        end
        m_cq  = '0;
        m_cyc = 0;
    endtask

    task automatic model_edge(input logic [CH-1:0] din);
        int pwm;
        bit tk;
        int nd;
        pwm = m_cyc % (MAXD + 1);
        tk  = ((m_cyc % PS) == PS - 1);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                exp_led[d][c]  = ((m_dir[d][c] == 0) && (m_duty[d][c] == MAXD)) || (pwm < m_duty[d][c]);
                exp_busy[d][c] = (m_dir[d][c] != 0);
                if (m_dir[d][c] == 0) begin
                    if (m_duty[d][c] == 0 && m_cq[c])         m_dir[d][c] = 1;
                    else if (m_duty[d][c] == MAXD && !m_cq[c]) m_dir[d][c] = -1;
                end else if ((m_dir[d][c] > 0) != m_cq[c]) begin
                    m_dir[d][c] = -m_dir[d][c];
                end else if ((m_dir[d][c] > 0 && m_duty[d][c] == MAXD) ||
                             (m_dir[d][c] < 0 && m_duty[d][c] == 0)) begin
                    m_dir[d][c] = 0;
                end else if (tk) begin
                    nd = m_duty[d][c] + m_dir[d][c] * m_step[d];
                    if (nd > MAXD) nd = MAXD;
                    if (nd < 0)    nd = 0;
                    m_duty[d][c] = nd;
                end
            end
        end
        m_cq = din;
        m_cyc++;
    endtask

    task automatic compare_all(input string pfx);
        check_eq({pfx, "_s1_led"},  bus_a.led_out, exp_led[0]);
        check_eq({pfx, "_s1_busy"}, bus_a.busy,    exp_busy[0]);
        check_eq({pfx, "_s4_led"},  bus_b.led_out, exp_led[1]);
        check_eq({pfx, "_s4_busy"}, bus_b.busy,    exp_busy[1]);
    endtask

    task automatic step_cycle(input string pfx);
        @(posedge clk);
        if (reset_n) model_edge(cur);
        #1;
        compare_all(pfx);
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        cur = 2'b11;
        repeat (3) step_cycle("in_rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cur = 2'b11;
        repeat (4) step_cycle("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) step_cycle("rel");

        cur = 2'b00;
        repeat (90) step_cycle("fall_all");
        cur = 2'b01;
        repeat (90) step_cycle("rise0");
        cur = 2'b00;
        repeat (90) step_cycle("fall0");
        cur = 2'b01;
        repeat (30) step_cycle("rise_part");
        cur = 2'b00;
        repeat (50) step_cycle("reverse");
        cur = 2'b01;
        repeat (40) step_cycle("pre_rst");
        mid_reset();
        repeat (20) step_cycle("post_rst");

        for (int seg = 0; seg < 40; seg++) begin
            cur = CH'($urandom_range(0, 3));
            repeat ($urandom_range(1, 110)) step_cycle("rand");
            if (seg % 13 == 6) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
